ccff_stream_loader: RTL and testbench

Synthesizable configuration-chain loader that sits directly upstream of the fabric's `ccff_head` input. Fetches the bitstream word-by-word from a memory port, serializes it LSB-first onto `ccff_head` with a qualifying shift enable, counts exactly `BS_LGT` shifts and raises `config_done`. Replaces testbench-driven head stimulus for on-chip and emulation bring-up. An optional verify pass re-shifts the same stream and compares `ccff_tail` bit-for-bit.

---
 rtl/ccff_stream_loader_if.sv | 24 ++
 rtl/ccff_stream_loader.sv | 148 ++++++++++++++
 tb/tb_ccff_stream_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_stream_loader_if.sv
// Memory read port and configuration-chain head/tail bundle for ccff_stream_loader.
// master = loader side, slave = memory + fabric side.
interface ccff_stream_loader_if #(
   parameter int ADDR_W = 9,
   parameter int WORD_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic [WORD_W-1:0] mem_rdata;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;

   modport master (
      output mem_req, mem_addr, ccff_head, ccff_shift_en,
      input  mem_valid, mem_rdata, ccff_tail
   );

   modport slave (
      input  mem_req, mem_addr, ccff_head, ccff_shift_en,
      output mem_valid, mem_rdata, ccff_tail
   );
endinterface

// File: rtl/ccff_stream_loader.sv
// Fetches the bitstream word-by-word and shifts it LSB-first into ccff_head.
// Define CCFF_VERIFY_EN to add a second pass that checks ccff_tail against the re-shifted stream.
module ccff_stream_loader #(
   parameter int BS_LGT = 8387,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 14
) (
   input  logic                  prog_clk,
   input  logic                  pReset,
   input  logic                  start,
   ccff_stream_loader_if.master  bus,
   output logic                  busy,
   output logic                  config_done,
   output logic [CNT_W-1:0]      bit_count,
   output logic                  verify_err,
   output logic [15:0]           err_count
);
   localparam int IDX_W = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] word_q;
   logic [IDX_W-1:0]  idx_q, idx_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              head_q, shen_q;
   logic              head_d, shen_d;
   logic              accept, last_bit, last_in_word, refetch;

   assign accept       = start && (state_q == IDLE || state_q == DONE);
   assign last_bit     = (cnt_q == CNT_W'(BS_LGT - 1));
   assign last_in_word = (idx_q == IDX_W'(WORD_W - 1));
   assign idx_nxt      = idx_q + IDX_W'(1);

`ifdef CCFF_VERIFY_EN
   logic        pass_q;
   logic        verr_q;
   logic [15:0] ecnt_q;

   // End of the first pass loops back for the verify pass.
   assign refetch = !pass_q;

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         pass_q <= 1'b0;
         verr_q <= 1'b0;
         ecnt_q <= '0;
      end else if (accept) begin
         pass_q <= 1'b0;
         verr_q <= 1'b0;
         ecnt_q <= '0;
      end else begin
         if (state_q == SHIFT && last_bit) pass_q <= 1'b1;
         if (pass_q && shen_q && (bus.ccff_tail != head_q)) begin
            verr_q <= 1'b1;
            if (ecnt_q != 16'hFFFF) ecnt_q <= ecnt_q + 16'd1;
         end
      end
   end

   assign verify_err = verr_q;
   assign err_count  = ecnt_q;
`else
   logic unused_tail;

   assign refetch     = 1'b0;
   assign unused_tail = bus.ccff_tail;
   assign verify_err  = 1'b0;
   assign err_count   = '0;
`endif

   always_ff @(posedge prog_clk) begin
      if (pReset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = FETCH;
         FETCH:      if (bus.mem_valid) state_d = SHIFT;
         SHIFT: begin
            // Last bit of the pass wins over end-of-word, so an exact multiple never over-fetches.
            if (last_bit)          state_d = refetch ? FETCH : DONE;
            else if (last_in_word) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req = (state_q == FETCH);
      busy        = (state_q == FETCH) || (state_q == SHIFT);
      config_done = (state_q == DONE);
      shen_d      = (state_d == SHIFT);
      head_d      = 1'b0;
      if (state_d == SHIFT)
         head_d = (state_q == FETCH) ? bus.mem_rdata[0] : word_q[idx_nxt];
   end

   // head/shift_en are registered from next-state so they stay aligned and glitch-free.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         head_q <= 1'b0;
         shen_q <= 1'b0;
         word_q <= '0;
         idx_q  <= '0;
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         shen_q <= shen_d;
         if (accept) begin
            addr_q <= '0;
            cnt_q  <= '0;
         end else begin
            unique case (state_q)
               FETCH: begin
                  if (bus.mem_valid) begin
                     word_q <= bus.mem_rdata;
                     idx_q  <= '0;
                  end
               end
               SHIFT: begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  idx_q <= idx_nxt;
                  if (last_bit) begin
                     if (refetch) begin
                        addr_q <= '0;
                        cnt_q  <= '0;
                     end
                  end else if (last_in_word) begin
                     addr_q <= addr_q + ADDR_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ccff_head     = head_q;
   assign bus.ccff_shift_en = shen_q;
   assign bit_count         = cnt_q;
   assign bus.mem_addr      = addr_q;
endmodule

// File: tb/tb_ccff_stream_loader.sv
// Scoreboard bench for ccff_stream_loader: a 70-bit chain (partial last word) and a 64-bit chain (exact multiple).
// Expected stream bits and read addresses are queued at start; monitors pop them as the DUTs shift/read.
module tb_ccff_stream_loader;
`ifdef CCFF_VERIFY_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int WW  = 32;
   localparam int LA  = 70;
   localparam int AWA = 4;
   localparam int LB  = 64;
   localparam int AWB = 2;
   localparam int CW  = 7;

   logic clk = 1'b0;
   logic rst, start_a, start_b;
   always #5 clk = ~clk;

   ccff_stream_loader_if #(.ADDR_W(AWA), .WORD_W(WW)) ba();
   ccff_stream_loader_if #(.ADDR_W(AWB), .WORD_W(WW)) bb();

   logic          busy_a, done_a, verr_a, busy_b, done_b, verr_b;
   logic [CW-1:0] cnt_a, cnt_b;
   logic [15:0]   ecnt_a, ecnt_b;

   ccff_stream_loader #(.BS_LGT(LA), .WORD_W(WW), .ADDR_W(AWA), .CNT_W(CW)) dut_a (
      .prog_clk(clk), .pReset(rst), .start(start_a), .bus(ba), .busy(busy_a),
      .config_done(done_a), .bit_count(cnt_a), .verify_err(verr_a), .err_count(ecnt_a));

   ccff_stream_loader #(.BS_LGT(LB), .WORD_W(WW), .ADDR_W(AWB), .CNT_W(CW)) dut_b (
      .prog_clk(clk), .pReset(rst), .start(start_b), .bus(bb), .busy(busy_b),
      .config_done(done_b), .bit_count(cnt_b), .verify_err(verr_b), .err_count(ecnt_b));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   logic [WW-1:0] mem_a [16];
   logic [WW-1:0] mem_b [4];
   bit            exp_a[$], exp_b[$];
   int            eaddr_a[$], eaddr_b[$];
   int            dly_mode;     // 0..3 fixed wait, -1 random 0..3
   int            shifts_a = 0, shifts_b = 0, reads_b = 0;
   bit            inj_a;

   // Chain models: plain shift registers; tail of A can be flipped on second-pass bit 5.
   logic [LA-1:0] sr_a = '0;
   logic [LB-1:0] sr_b = '0;
   int            chain_n_a = 0;
   always @(posedge clk) begin
      if (ba.ccff_shift_en) sr_a <= {sr_a[LA-2:0], ba.ccff_head};
      if (bb.ccff_shift_en) sr_b <= {sr_b[LB-2:0], bb.ccff_head};
      if (rst || start_a)        chain_n_a <= 0;
      else if (ba.ccff_shift_en) chain_n_a <= chain_n_a + 1;
   end
   assign ba.ccff_tail = sr_a[LA-1] ^ (inj_a && chain_n_a == LA + 5);
   assign bb.ccff_tail = sr_b[LB-1];

   // Memory responder A: variable wait, checks address order and stability.
   initial begin
      int wcnt, tgt, held;
      wcnt = 0; tgt = 0; held = 0;
      ba.mem_valid = 1'b0;
      ba.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (ba.mem_valid) begin
            ba.mem_valid = 1'b0;
            wcnt = 0;
         end else if (!ba.mem_req) begin
            wcnt = 0;
         end else begin
            if (wcnt == 0) begin
               held = int'(ba.mem_addr);
               tgt  = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
            end else begin
               chk("a_addr_stable", ba.mem_addr, held);
            end
            if (wcnt >= tgt) begin
               ba.mem_valid = 1'b1;
               ba.mem_rdata = mem_a[ba.mem_addr];
               if (eaddr_a.size() == 0) chk("a_extra_read", ba.mem_addr, -1);
               else                     chk("a_read_addr", ba.mem_addr, eaddr_a.pop_front());
            end
            wcnt++;
         end
      end
   end

   // Memory responder B: zero-wait.
   initial begin
      bb.mem_valid = 1'b0;
      bb.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bb.mem_valid) begin
            bb.mem_valid = 1'b0;
         end else if (bb.mem_req) begin
            bb.mem_valid = 1'b1;
            bb.mem_rdata = mem_b[bb.mem_addr];
            reads_b++;
            if (eaddr_b.size() == 0) chk("b_extra_read", bb.mem_addr, -1);
            else                     chk("b_read_addr", bb.mem_addr, eaddr_b.pop_front());
         end
      end
   end

   // Stream monitors.
   initial forever begin
      @(negedge clk);
      if (ba.ccff_shift_en) begin
         shifts_a++;
         chk("a_shift_during_fetch", ba.mem_req, 0);
         if (exp_a.size() == 0) chk("a_extra_shift", shifts_a, -1);
         else                   chk("a_head_bit", ba.ccff_head, exp_a.pop_front());
      end else begin
         chk("a_head_idle_zero", ba.ccff_head, 0);
      end
   end

   initial forever begin
      @(negedge clk);
      if (bb.ccff_shift_en) begin
         shifts_b++;
         if (exp_b.size() == 0) chk("b_extra_shift", shifts_b, -1);
         else                   chk("b_head_bit", bb.ccff_head, exp_b.pop_front());
      end
   end

   task automatic fill_a(input int pat);
      for (int w = 0; w < 16; w++)
         case (pat)
            0:       mem_a[w] = $urandom();
            1:       mem_a[w] = 32'hFFFF_FFFF;
            default: mem_a[w] = 32'hA5C3_0000 | w;
         endcase
   endtask

   // Reference: stream bit i = word[i/WW] bit (i%WW), one full stream per pass.
   task automatic start_pulse_a(input bit push);
      @(negedge clk);
      start_a = 1'b1;
      if (push)
         for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < LA; i++) exp_a.push_back(mem_a[i / WW][i % WW]);
            for (int w = 0; w < (LA + WW - 1) / WW; w++) eaddr_a.push_back(w);
         end
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string tag, input int exp_err);
      int k = 0;
      while (!done_a && k < 2000) begin @(negedge clk); k++; end
      chk({tag, "_done"}, done_a, 1);
      chk({tag, "_busy"}, busy_a, 0);
      chk({tag, "_bits_left"}, exp_a.size(), 0);
      chk({tag, "_reads_left"}, eaddr_a.size(), 0);
      chk({tag, "_bit_count"}, cnt_a, LA);
      chk({tag, "_err_count"}, ecnt_a, (PASSES == 2) ? exp_err : 0);
      chk({tag, "_verify_err"}, verr_a, (PASSES == 2 && exp_err != 0) ? 1 : 0);
   endtask

   task automatic load_a(input int pat, input int dly, input string tag, input int exp_err);
      fill_a(pat);
      dly_mode = dly;
      start_pulse_a(1'b1);
      chk({tag, "_done_drops"}, done_a, 0);
      chk({tag, "_busy_rises"}, busy_a, 1);
      wait_done_a(tag, exp_err);
   endtask

   task automatic wait_shifts_a(input int n, input string tag);
      int base = shifts_a;
      int k = 0;
      while (shifts_a < base + n && k < 1000) begin @(negedge clk); k++; end
      chk({tag, "_progress"}, (shifts_a - base >= n) ? 1 : 0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; dly_mode = 0; inj_a = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_mem_req", ba.mem_req, 0);
      chk("rst_shift_en", ba.ccff_shift_en, 0);
      chk("rst_bit_count", cnt_a, 0);
      chk("rst_err_count", ecnt_a, 0);
      chk("rst_b_done", done_b, 0);
      rst = 1'b0;
      @(negedge clk);

      // Exact multiple: 2 reads, 64 shifts per pass.
      for (int w = 0; w < 4; w++) mem_b[w] = $urandom();
      start_b = 1'b1;
      for (int p = 0; p < PASSES; p++) begin
         for (int i = 0; i < LB; i++) exp_b.push_back(mem_b[i / WW][i % WW]);
         for (int w = 0; w < LB / WW; w++) eaddr_b.push_back(w);
      end
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < 1000 && !done_b; k++) @(negedge clk);
      chk("b_done", done_b, 1);
      chk("b_reads", reads_b, 2 * PASSES);
      chk("b_shifts", shifts_b, LB * PASSES);
      chk("b_bits_left", exp_b.size(), 0);
      chk("b_bit_count", cnt_b, LB);
      chk("b_err_count", ecnt_b, 0);

      load_a(0, 0,  "zw_rand", 0);
      load_a(1, 3,  "dly3_ones", 0);
      load_a(2, -1, "rnd_pat", 0);
      load_a(0, -1, "rnd_rand", 0);

      inj_a = 1'b1;
      load_a(0, 1, "inject", 1);
      inj_a = 1'b0;

      // start while busy must not disturb the stream.
      fill_a(0);
      dly_mode = -1;
      start_pulse_a(1'b1);
      wait_shifts_a(30, "ign");
      start_pulse_a(1'b0);
      wait_done_a("ign_start", 0);

      // Reset mid-shift, then a full reload from address 0.
      fill_a(0);
      dly_mode = 2;
      start_pulse_a(1'b1);
      wait_shifts_a(40, "rst40");
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_done", done_a, 0);
      chk("mid_rst_mem_req", ba.mem_req, 0);
      chk("mid_rst_mem_addr", ba.mem_addr, 0);
      chk("mid_rst_shift_en", ba.ccff_shift_en, 0);
      chk("mid_rst_head", ba.ccff_head, 0);
      chk("mid_rst_bit_count", cnt_a, 0);
      chk("mid_rst_err_count", ecnt_a, 0);
      rst = 1'b0;
      exp_a.delete();
      eaddr_a.delete();
      @(negedge clk);
      load_a(0, 0, "post_rst", 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
